// File: rtl/irq_exc_sequencer.sv
// ----------------------------------------------------------------------------
// irq_exc_sequencer
//
// Interrupt / exception sequencer for the pipelined MIPS core. It sits beside
// the ID-stage control decoder and overrides its PC select when an interrupt
// or an illegal-instruction exception has to be taken.
//
// Operation
//   - Edge-detects N_IRQ request lines into a pending register.
//   - Applies the software mask and a fixed lowest-index-wins priority.
//   - Waits for a safe ID-stage slot: a valid instruction, not stalled and
//     not in a delay slot.
//   - Issues a one-cycle redirect (take_o) carrying the vector PC, EPC and
//     cause, then tracks kernel mode until ERET is accepted (ret_o).
//   - An illegal opcode beats a same-cycle interrupt; the interrupt stays
//     pending.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   irq_req        in   raw request levels, synchronous to clk
//   mask_we        in   write enable for irq_mask
//   mask_wdata     in   new mask value (1 = channel enabled)
//   instr_valid    in   ID stage holds a real (non-bubble) instruction
//   stall          in   ID stage is stalled this cycle
//   in_delay_slot  in   ID instruction sits in a branch/jump delay slot
//   illop          in   ID opcode is undefined
//   eret           in   ID instruction is ERET
//   id_pc          in   PC of the ID-stage instruction
//   take_o         out  one-cycle flush plus redirect to vector_pc
//   ret_o          out  one-cycle redirect to epc (ERET accepted)
//   vector_pc      out  redirect target; nonzero only while take_o is high
//   epc            out  exception return PC
//   cause          out  {is_exc, irq index[3:0]}
//   kernel         out  handler running; interrupts are blocked
//   irq_ack        out  one-hot acknowledge, pulses with take_o for an irq
//   irq_mask       out  current interrupt mask
// ----------------------------------------------------------------------------
module irq_exc_sequencer #(
    parameter int              N_IRQ   = 4,
    parameter int              PC_W    = 32,
    parameter logic [PC_W-1:0] IRQ_VEC = PC_W'(32'h8000_0008),
    parameter logic [PC_W-1:0] EXC_VEC = PC_W'(32'h8000_0004)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_req,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic             in_delay_slot,
    input  logic             illop,
    input  logic             eret,
    input  logic [PC_W-1:0]  id_pc,
    output logic             take_o,
    output logic             ret_o,
    output logic [PC_W-1:0]  vector_pc,
    output logic [PC_W-1:0]  epc,
    output logic [4:0]       cause,
    output logic             kernel,
    output logic [N_IRQ-1:0] irq_ack,
    output logic [N_IRQ-1:0] irq_mask
);

    typedef enum logic [1:0] {
        S_RUN,     // normal execution, nothing eligible
        S_WAIT,    // an irq is eligible but the ID slot is not safe yet
        S_TAKE,    // redirect cycle: take_o is high
        S_KERNEL   // handler running until ERET
    } state_t;

    localparam logic [4:0] CAUSE_EXC = 5'h10;

    state_t           state;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] irq_prev;

    logic [N_IRQ-1:0] set_vec;
    logic [N_IRQ-1:0] clr_vec;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] grant;
    logic [3:0]       grant_idx;
    logic             any_elig;
    logic             slot_ok;
    logic             fault;
    logic             deciding;
    logic             take_exc;
    logic             take_irq;
    logic             eret_ok;
    logic [PC_W-1:0]  exc_epc;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign set_vec  = irq_req & ~irq_prev;
    assign elig     = pend & irq_mask & ~{N_IRQ{kernel}};
    assign any_elig = |elig;
    assign slot_ok  = instr_valid & ~stall & ~in_delay_slot;
    assign fault    = illop & instr_valid & ~stall;

    // RUN and WAIT make the same take decisions; WAIT only records that an
    // eligible irq is being held back by an unsafe slot.
    assign deciding = (state == S_RUN) || (state == S_WAIT);
    assign take_exc = fault & (deciding | (state == S_KERNEL));
    assign take_irq = deciding & ~fault & any_elig & slot_ok;
    assign eret_ok  = (state == S_KERNEL) & ~fault & eret & instr_valid & ~stall;

    // A faulting delay-slot instruction must be re-executed after the
    // handler, so it returns to itself rather than to the next word.
    assign exc_epc  = in_delay_slot ? id_pc : id_pc + PC_W'(4);

    assign clr_vec  = take_irq ? grant : '0;

    // Fixed priority: walk from the top down so the lowest set index is the
    // last one written and therefore wins.
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending register, edge detector and mask
    // ------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            irq_prev <= '0;
            irq_mask <= '0;
        end else begin
            // A new edge on the bit being acknowledged must not be lost, so
            // the set term is applied after the clear term.
            pend     <= (pend & ~clr_vec) | set_vec;
            irq_prev <= irq_req;
            if (mask_we) begin
                irq_mask <= mask_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            take_o    <= 1'b0;
            ret_o     <= 1'b0;
            vector_pc <= '0;
            epc       <= '0;
            cause     <= '0;
            kernel    <= 1'b0;
            irq_ack   <= '0;
        end else begin
            // Pulse outputs default low; only the decision branches raise them.
            take_o    <= 1'b0;
            ret_o     <= 1'b0;
            vector_pc <= '0;
            irq_ack   <= '0;

            case (state)
                S_RUN, S_WAIT: begin
                    if (take_exc) begin
                        state     <= S_TAKE;
                        take_o    <= 1'b1;
                        vector_pc <= EXC_VEC;
                        epc       <= exc_epc;
                        cause     <= CAUSE_EXC;
                    end else if (take_irq) begin
                        state     <= S_TAKE;
                        take_o    <= 1'b1;
                        vector_pc <= IRQ_VEC;
                        epc       <= id_pc;
                        cause     <= {1'b0, grant_idx};
                        irq_ack   <= grant;
                    end else if (any_elig) begin
                        state <= S_WAIT;
                    end else begin
                        // Covers the mask being cleared while waiting.
                        state <= S_RUN;
                    end
                end

                S_TAKE: begin
                    state  <= S_KERNEL;
                    kernel <= 1'b1;
                end

                S_KERNEL: begin
                    if (take_exc) begin
                        // Nested fault: keep the original return address so
                        // the outer context is not lost.
                        state     <= S_TAKE;
                        take_o    <= 1'b1;
                        vector_pc <= EXC_VEC;
                        cause     <= CAUSE_EXC;
                    end else if (eret_ok) begin
                        state  <= S_RUN;
                        ret_o  <= 1'b1;
                        kernel <= 1'b0;
                    end
                end

                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule
